dmux_1to2: RTL and testbench



---
 rtl/dmux_pkg.sv | 12 +
 rtl/dmux_sat_cnt.sv | 32 +++
 rtl/dmux_1to2.sv | 82 ++++++++
 tb/tb_dmux_1to2.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dmux_pkg.sv
// Shared definitions for the 1-to-2 demultiplexer: default widths and the select encoding.
package dmux_pkg;

  localparam int DMUX_WIDTH_DEF = 1;
  localparam int DMUX_CNT_W_DEF = 16;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_t;

endpackage

// File: rtl/dmux_sat_cnt.sv
// Saturating up-counter with synchronous active-high clear and increment enable.
module dmux_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Holds at all-ones instead of wrapping back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dmux_1to2.sv
// 1-to-2 demultiplexer with combinational and registered outputs.
// Define DMUX_ROUTE_CNT_EN to add the per-output saturating route counters cnt_a/cnt_b.
module dmux_1to2
  import dmux_pkg::*;
#(
  parameter int WIDTH = DMUX_WIDTH_DEF,
  parameter int CNT_W = DMUX_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             sel,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q
`ifdef DMUX_ROUTE_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
`endif
);

  sel_t             sel_e;
  logic [WIDTH-1:0] a_q_d;
  logic [WIDTH-1:0] b_q_d;

  assign sel_e = sel_t'(sel);

  // Stage p0: combinational routing; the unselected side is forced to zero.
  always_comb begin
    a = '0;
    b = '0;
    if (sel_e == SEL_A) begin
      a = in;
    end else begin
      b = in;
    end
  end

  assign a_q_d = a;
  assign b_q_d = b;

  // Stage p1: registered copies of a/b for timing-closed consumers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_q_d;
      b_q <= b_q_d;
    end
  end

`ifdef DMUX_ROUTE_CNT_EN
  logic inc_a;
  logic inc_b;

  // All-zero data is not a routed event, so it does not count.
  assign inc_a = (sel_e == SEL_A) && (|in);
  assign inc_b = (sel_e == SEL_B) && (|in);

  dmux_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt_a (
    .clk   (clk),
    .rst   (rst),
    .inc_i (inc_a),
    .cnt_o (cnt_a)
  );

  dmux_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt_b (
    .clk   (clk),
    .rst   (rst),
    .inc_i (inc_b),
    .cnt_o (cnt_b)
  );
`endif

endmodule

// File: tb/tb_dmux_1to2.sv
// Scoreboard bench for dmux_1to2 at WIDTH=1 and WIDTH=8; counter checks when DMUX_ROUTE_CNT_EN is defined.
module tb_dmux_1to2;

  localparam int CW     = 4;
  localparam int CNTMAX = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [0:0] in1 = '0;
  logic [7:0] in8 = '0;
  logic       sel = 1'b0;
  logic [0:0] a1, b1, aq1, bq1;
  logic [7:0] a8, b8, aq8, bq8;
`ifdef DMUX_ROUTE_CNT_EN
  logic [CW-1:0] cnt_a1, cnt_b1, cnt_a8, cnt_b8;
`endif

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [0:0] aq1;
    logic [0:0] bq1;
    logic [7:0] aq8;
    logic [7:0] bq8;
    int         ca;
    int         cb;
  } exp_t;

  exp_t q[$];
  int   m_ca = 0;
  int   m_cb = 0;

  always #5 clk = ~clk;

  dmux_1to2 #(.WIDTH(1), .CNT_W(CW)) u_dut1 (
    .clk (clk), .rst (rst), .in (in1), .sel (sel),
    .a (a1), .b (b1), .a_q (aq1), .b_q (bq1)
`ifdef DMUX_ROUTE_CNT_EN
    , .cnt_a (cnt_a1), .cnt_b (cnt_b1)
`endif
  );

  dmux_1to2 #(.WIDTH(8), .CNT_W(CW)) u_dut8 (
    .clk (clk), .rst (rst), .in (in8), .sel (sel),
    .a (a8), .b (b8), .a_q (aq8), .b_q (bq8)
`ifdef DMUX_ROUTE_CNT_EN
    , .cnt_a (cnt_a8), .cnt_b (cnt_b8)
`endif
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: what the registers (and counters) must hold after the coming edge.
  function automatic void push_exp(input logic r, input logic i1, input logic [7:0] i8, input logic s);
    exp_t e;
    if (r) begin
      e.aq1 = '0; e.bq1 = '0; e.aq8 = '0; e.bq8 = '0;
      m_ca = 0; m_cb = 0;
    end else begin
      e.aq1 = s ? 1'b0 : i1;
      e.bq1 = s ? i1 : 1'b0;
      e.aq8 = s ? 8'h00 : i8;
      e.bq8 = s ? i8 : 8'h00;
      if (i1 != 1'b0) begin
        if (!s) m_ca = (m_ca < CNTMAX) ? m_ca + 1 : CNTMAX;
        else    m_cb = (m_cb < CNTMAX) ? m_cb + 1 : CNTMAX;
      end
    end
    e.ca = m_ca;
    e.cb = m_cb;
    q.push_back(e);
  endfunction

  task automatic step(input logic r, input logic i1, input logic [7:0] i8, input logic s);
    @(negedge clk);
    rst = r; in1 = i1; in8 = i8; sel = s;
    #1;
    chk("a1_comb", 32'(a1), s ? 32'd0 : 32'(i1));
    chk("b1_comb", 32'(b1), s ? 32'(i1) : 32'd0);
    chk("a8_comb", 32'(a8), s ? 32'd0 : 32'(i8));
    chk("b8_comb", 32'(b8), s ? 32'(i8) : 32'd0);
    push_exp(r, i1, i8, s);
  endtask

  // Monitor: one expectation per captured edge, compared just after that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("aq1", 32'(aq1), 32'(e.aq1));
        chk("bq1", 32'(bq1), 32'(e.bq1));
        chk("aq8", 32'(aq8), 32'(e.aq8));
        chk("bq8", 32'(bq8), 32'(e.bq8));
`ifdef DMUX_ROUTE_CNT_EN
        chk("cnt_a", 32'(cnt_a1), 32'(e.ca));
        chk("cnt_b", 32'(cnt_b1), 32'(e.cb));
`endif
      end
    end
  end

  initial begin
    logic [1:0] tt [4];
    tt[0] = 2'b00; tt[1] = 2'b00; tt[2] = 2'b10; tt[3] = 2'b01;

    // Reset for two cycles with in=1, sel=0: a follows input, registers held at 0.
    step(1'b1, 1'b1, 8'h3C, 1'b0);
    step(1'b1, 1'b1, 8'h3C, 1'b0);
    step(1'b0, 1'b1, 8'h3C, 1'b0);

    // Truth-table sweep at 1-unit steps, zero-delay outputs.
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in1 = k[1];
      sel = k[0];
      #1;
      chk("sweep_a", 32'(a1), 32'(tt[k][1]));
      chk("sweep_b", 32'(b1), 32'(tt[k][0]));
    end
    push_exp(1'b0, in1, in8, sel);

    // Registered path, then WIDTH=8 routing of A5.
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'hA5, 1'b1);
    step(1'b0, 1'b1, 8'hA5, 1'b0);

    // Saturation: 20 cycles routed to a, then a 1-cycle reset.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 8'h11, 1'b0);
`ifdef DMUX_ROUTE_CNT_EN
    @(posedge clk); #2;
    chk("cnt_a_sat", 32'(cnt_a1), 32'd15);
    chk("cnt_b_idle", 32'(cnt_b1), 32'd0);
`endif
    step(1'b1, 1'b1, 8'h11, 1'b0);

    // Zero data with sel toggling is never counted.
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 8'h00, k[0]);
`ifdef DMUX_ROUTE_CNT_EN
    @(posedge clk); #2;
    chk("cnt_a_zero", 32'(cnt_a1), 32'd0);
    chk("cnt_b_zero", 32'(cnt_b1), 32'd0);
`endif

    // Randomised traffic with occasional reset.
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 15) == 0), 1'($urandom), 8'($urandom), 1'($urandom));
    end

    for (int n = 0; n < 10 && q.size() > 0; n++) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
